// File: rtl/mram_pkg.sv
// mram_pkg: shared definitions for the MRAM datapath blocks.
//   - bus widths for the parallel MRAM pins
//   - sequencer FSM state type
//   - idle (deasserted) level of the active-low strobes, shared by the serial
//     front end, the bus sequencer and the parallel-to-serial return stage
package mram_pkg;

  localparam int MRAM_ADDR_W = 20;
  localparam int MRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_PULSE,
    ST_RD_ACCESS,
    ST_HOLD
  } mram_state_t;

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } mram_strobe_t;

  localparam mram_strobe_t MRAM_STROBE_IDLE = mram_strobe_t'(5'b11111);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mram_bus_ctrl_if.sv
// mram_bus_ctrl_if: request/response handshake between the serial front end
// (master) and the MRAM bus sequencer (slave).
//   req_valid/req_ready  request handshake, accepted when both high at clk edge
//   req_write/addr/wdata/byte_en  transaction fields
//   rsp_valid  one-cycle completion pulse, rsp_rdata  captured read word
interface mram_bus_ctrl_if;
  import mram_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [MRAM_ADDR_W-1:0] req_addr;
  logic [MRAM_DATA_W-1:0] req_wdata;
  logic [1:0]             req_byte_en;
  logic                   rsp_valid;
  logic [MRAM_DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mram_cycle_timer.sv
// mram_cycle_timer: loadable down-counter timing each sequencer phase.
//   clk, rst   clock, synchronous active-high reset
//   load       load load_val this cycle (takes priority over decrement)
//   load_val   phase length minus one
//   done       counter is at zero: current cycle is the last of the phase
module mram_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mram_bus_ctrl.sv
// mram_bus_ctrl: MRAM timing sequencer. Takes one transaction at a time over
// the bus interface and runs a counter-timed write or read cycle on the pins.
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      request/response handshake
//   mram_addr        address pins
//   mram_dq_out/oe   write data and DQ output enable (IOBUF built above)
//   mram_dq_in       read data from the pins
//   mram_*_n         active-low chip/write/output/byte strobes
// Every pin is a flop loaded from the next-state decode, so nothing on the
// request side reaches the pins combinationally.
module mram_bus_ctrl
  import mram_pkg::*;
#(
  parameter int SETUP_CYC     = 1,
  parameter int WR_PULSE_CYC  = 3,
  parameter int RD_ACCESS_CYC = 3,
  parameter int HOLD_CYC      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mram_bus_ctrl_if.slave         bus,
  output logic [MRAM_ADDR_W-1:0] mram_addr,
  output logic [MRAM_DATA_W-1:0] mram_dq_out,
  output logic                   mram_dq_oe,
  input  logic [MRAM_DATA_W-1:0] mram_dq_in,
  output logic                   mram_ce_n,
  output logic                   mram_we_n,
  output logic                   mram_oe_n,
  output logic                   mram_lb_n,
  output logic                   mram_ub_n
);

  localparam int CW = $clog2(max4(SETUP_CYC, WR_PULSE_CYC, RD_ACCESS_CYC, HOLD_CYC) + 1);

  mram_state_t  state, state_nxt;
  logic         accept, done, ld;
  logic [CW-1:0] ld_val;
  logic         is_wr, wr_nxt;
  logic [1:0]   be, be_nxt;
  mram_strobe_t stb_nxt;
  logic         dq_oe_nxt;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && (state == ST_IDLE);

  mram_cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .done     (done)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state; the timer is reloaded on every phase change
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_val    = '0;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_SETUP;
        ld        = 1'b1;
        ld_val    = CW'(SETUP_CYC - 1);
      end
      ST_SETUP: if (done) begin
        state_nxt = is_wr ? ST_WR_PULSE : ST_RD_ACCESS;
        ld        = 1'b1;
        ld_val    = is_wr ? CW'(WR_PULSE_CYC - 1) : CW'(RD_ACCESS_CYC - 1);
      end
      ST_WR_PULSE, ST_RD_ACCESS: if (done) begin
        state_nxt = ST_HOLD;
        ld        = 1'b1;
        ld_val    = CW'(HOLD_CYC - 1);
      end
      ST_HOLD: if (done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // pin decode for the coming cycle; on the accept edge the latches are not
  // loaded yet, so take direction/byte enables straight from the request
  assign wr_nxt = accept ? bus.req_write   : is_wr;
  assign be_nxt = accept ? bus.req_byte_en : be;

  always_comb begin
    stb_nxt   = MRAM_STROBE_IDLE;
    dq_oe_nxt = 1'b0;
    if (state_nxt != ST_IDLE) begin
      stb_nxt.ce_n = 1'b0;
      stb_nxt.lb_n = ~be_nxt[0];
      stb_nxt.ub_n = ~be_nxt[1];
      dq_oe_nxt    = wr_nxt;
    end
    case (state_nxt)
      ST_WR_PULSE:  stb_nxt.we_n = 1'b0;
      ST_RD_ACCESS: begin
        stb_nxt.oe_n = 1'b0;
        dq_oe_nxt    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n} <= MRAM_STROBE_IDLE;
      mram_dq_oe    <= 1'b0;
      mram_addr     <= '0;
      mram_dq_out   <= '0;
      is_wr         <= 1'b0;
      be            <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      {mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n} <= stb_nxt;
      mram_dq_oe    <= dq_oe_nxt;
      bus.rsp_valid <= (state == ST_HOLD) && done;
      if (accept) begin
        mram_addr <= bus.req_addr;
        is_wr     <= bus.req_write;
        be        <= bus.req_byte_en;
        if (bus.req_write) mram_dq_out <= bus.req_wdata;
      end
      // capture on the edge closing the last OE-low cycle
      if (state == ST_RD_ACCESS && done)
        bus.rsp_rdata <= mram_dq_in & {{8{be[1]}}, {8{be[0]}}};
    end
  end

  param_min_a: assert property (@(posedge clk)
    (SETUP_CYC >= 1) && (WR_PULSE_CYC >= 1) && (RD_ACCESS_CYC >= 1) && (HOLD_CYC >= 1));

endmodule

// File: tb/tb_mram_bus_ctrl.sv
module tb_mram_bus_ctrl;
  import mram_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } rsp_t;

  localparam logic [6:0] IDLE_V = 7'b1111101; // {ce,we,oe,lb,ub,dq_oe,ready}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  mram_bus_ctrl_if bus0();
  mram_bus_ctrl_if bus1();

  logic [19:0] addr0, addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
  logic        dq_oe0, dq_oe1;
  logic        ce_n0, we_n0, oe_n0, lb_n0, ub_n0;
  logic        ce_n1, we_n1, oe_n1, lb_n1, ub_n1;
  logic [15:0] model_word = 16'h0000;
  logic [15:0] exp_rdata = 16'h0000;

  // memory model: drives the stored word only while OE is low
  assign dq_in0 = oe_n0 ? 16'hDEAD : model_word;
  assign dq_in1 = oe_n1 ? 16'hDEAD : 16'h5A5A;

  mram_bus_ctrl dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .mram_addr(addr0), .mram_dq_out(dq_out0), .mram_dq_oe(dq_oe0), .mram_dq_in(dq_in0),
    .mram_ce_n(ce_n0), .mram_we_n(we_n0), .mram_oe_n(oe_n0), .mram_lb_n(lb_n0), .mram_ub_n(ub_n0)
  );

  mram_bus_ctrl #(.SETUP_CYC(2), .WR_PULSE_CYC(1), .RD_ACCESS_CYC(3), .HOLD_CYC(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .mram_addr(addr1), .mram_dq_out(dq_out1), .mram_dq_oe(dq_oe1), .mram_dq_in(dq_in1),
    .mram_ce_n(ce_n1), .mram_we_n(we_n1), .mram_oe_n(oe_n1), .mram_lb_n(lb_n1), .mram_ub_n(ub_n1)
  );

  rsp_t sb0[$], obs0[$], sb1[$], obs1[$];
  rsp_t mon0, mon1;

  always @(negedge clk) begin
    if (bus0.rsp_valid === 1'b1) begin
      mon0.cyc = cyc; mon0.rdata = bus0.rsp_rdata; obs0.push_back(mon0);
    end
    if (bus1.rsp_valid === 1'b1) begin
      mon1.cyc = cyc; mon1.rdata = bus1.rsp_rdata; obs1.push_back(mon1);
    end
  end

  function automatic logic [6:0] pins0();
    return {ce_n0, we_n0, oe_n0, lb_n0, ub_n0, dq_oe0, bus0.req_ready};
  endfunction

  function automatic logic [6:0] pins1();
    return {ce_n1, we_n1, oe_n1, lb_n1, ub_n1, dq_oe1, bus1.req_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a request on dut0 and optionally record the expected response
  task automatic req0(input logic wr, input logic [19:0] a, input logic [15:0] d,
                      input logic [1:0] be, input int rsp_cyc, input logic [15:0] rd);
    rsp_t e;
    bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_addr = a;
    bus0.req_wdata = d;    bus0.req_byte_en = be;
    if (rsp_cyc >= 0) begin
      e.cyc = rsp_cyc; e.rdata = rd; sb0.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (pins0() !== IDLE_V) begin n_fail++; $display("FAIL reset pins0: got %b expected %b", pins0(), IDLE_V); end
    n_chk++; if (pins1() !== IDLE_V) begin n_fail++; $display("FAIL reset pins1: got %b expected %b", pins1(), IDLE_V); end
    n_chk++; if (bus0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b expected 0", bus0.rsp_valid); end
    n_chk++; if (bus0.rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset rsp_rdata: got %h expected 0000", bus0.rsp_rdata); end
    n_chk++; if (addr0 !== 20'h0) begin n_fail++; $display("FAIL reset addr: got %h expected 00000", addr0); end
    n_chk++; if (dq_out0 !== 16'h0) begin n_fail++; $display("FAIL reset dq_out: got %h expected 0000", dq_out0); end
    step();
  endtask

  task automatic test_write();
    int c0;
    logic [6:0] ev;
    rsp_t e, o;
    c0 = cyc;
    req0(1'b1, 20'h0A5C3, 16'hBEEF, 2'b11, c0 + 6, exp_rdata);
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) bus0.req_valid = 1'b0;
      @(negedge clk);
      ev = (c >= 1 && c <= 5) ? {1'b0, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1'b1, 2'b00, 1'b1, 1'b0} : IDLE_V;
      n_chk++; if (pins0() !== ev) begin n_fail++; $display("FAIL write pins c%0d: got %b expected %b", c, pins0(), ev); end
      if (c >= 1) begin
        n_chk++; if ({addr0, dq_out0} !== {20'h0A5C3, 16'hBEEF}) begin n_fail++; $display("FAIL write addr/data c%0d: got %h/%h expected 0a5c3/beef", c, addr0, dq_out0); end
      end
      step();
    end
    while (sb0.size() > 0) begin
      e = sb0.pop_front(); n_chk++;
      if (obs0.size() == 0) begin n_fail++; $display("FAIL write rsp: got none expected cycle %0d", e.cyc - c0); end
      else begin
        o = obs0.pop_front();
        if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin n_fail++; $display("FAIL write rsp: got c%0d %h expected c%0d %h", o.cyc - c0, o.rdata, e.cyc - c0, e.rdata); end
      end
    end
    n_chk++; if (obs0.size() != 0) begin n_fail++; $display("FAIL write extra rsp: got %0d expected 0", obs0.size()); end
    obs0.delete();
  endtask

  task automatic test_read();
    int c0;
    logic [6:0] ev;
    rsp_t e, o;
    model_word = 16'h1234;
    c0 = cyc;
    req0(1'b0, 20'h00010, 16'hFFFF, 2'b11, c0 + 6, 16'h1234);
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) bus0.req_valid = 1'b0;
      @(negedge clk);
      ev = (c >= 1 && c <= 5) ? {1'b0, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 2'b00, 1'b0, 1'b0} : IDLE_V;
      n_chk++; if (pins0() !== ev) begin n_fail++; $display("FAIL read pins c%0d: got %b expected %b", c, pins0(), ev); end
      step();
    end
    exp_rdata = 16'h1234;
    n_chk++; if (addr0 !== 20'h00010) begin n_fail++; $display("FAIL read addr: got %h expected 00010", addr0); end
    while (sb0.size() > 0) begin
      e = sb0.pop_front(); n_chk++;
      if (obs0.size() == 0) begin n_fail++; $display("FAIL read rsp: got none expected cycle %0d", e.cyc - c0); end
      else begin
        o = obs0.pop_front();
        if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin n_fail++; $display("FAIL read rsp: got c%0d %h expected c%0d %h", o.cyc - c0, o.rdata, e.cyc - c0, e.rdata); end
      end
    end
    n_chk++; if (obs0.size() != 0) begin n_fail++; $display("FAIL read extra rsp: got %0d expected 0", obs0.size()); end
    obs0.delete();
  endtask

  task automatic test_byte_read();
    logic [1:0]  be_t [3] = '{2'b01, 2'b10, 2'b00};
    logic [15:0] rd_t [3] = '{16'h00CD, 16'hAB00, 16'h0000};
    int c0;
    logic [6:0] ev;
    rsp_t e, o;
    model_word = 16'hABCD;
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      req0(1'b0, 20'h00020 + 20'(k), 16'h0000, be_t[k], c0 + 6, rd_t[k]);
      for (int c = 0; c <= 6; c++) begin
        if (c == 1) bus0.req_valid = 1'b0;
        @(negedge clk);
        ev = (c >= 1 && c <= 5) ? {1'b0, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, ~be_t[k][0], ~be_t[k][1], 1'b0, 1'b0} : IDLE_V;
        n_chk++; if (pins0() !== ev) begin n_fail++; $display("FAIL byte read be=%b pins c%0d: got %b expected %b", be_t[k], c, pins0(), ev); end
        step();
      end
      while (sb0.size() > 0) begin
        e = sb0.pop_front(); n_chk++;
        if (obs0.size() == 0) begin n_fail++; $display("FAIL byte read be=%b rsp: got none expected %h", be_t[k], e.rdata); end
        else begin
          o = obs0.pop_front();
          if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin n_fail++; $display("FAIL byte read be=%b rsp: got c%0d %h expected c%0d %h", be_t[k], o.cyc - c0, o.rdata, e.cyc - c0, e.rdata); end
        end
      end
      n_chk++; if (obs0.size() != 0) begin n_fail++; $display("FAIL byte read extra rsp: got %0d expected 0", obs0.size()); end
      obs0.delete();
    end
    exp_rdata = 16'h0000;
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [6:0] ev;
    rsp_t e, o;
    model_word = 16'hC3C3;
    c0 = cyc;
    req0(1'b1, 20'h00100, 16'h55AA, 2'b11, c0 + 6, exp_rdata);
    e.cyc = c0 + 12; e.rdata = 16'hC3C3; sb0.push_back(e);
    for (int c = 0; c <= 13; c++) begin
      if (c == 1) begin
        bus0.req_write = 1'b0; bus0.req_addr = 20'h00200; bus0.req_wdata = 16'h0000;
      end
      if (c == 7) bus0.req_valid = 1'b0;
      @(negedge clk);
      if (c >= 1 && c <= 5)
        ev = {1'b0, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
      else if (c >= 7 && c <= 11)
        ev = {1'b0, 1'b1, (c >= 8 && c <= 10) ? 1'b0 : 1'b1, 2'b00, 1'b0, 1'b0};
      else
        ev = IDLE_V;
      n_chk++; if (pins0() !== ev) begin n_fail++; $display("FAIL b2b pins c%0d: got %b expected %b", c, pins0(), ev); end
      if (c == 3) begin
        n_chk++; if (addr0 !== 20'h00100) begin n_fail++; $display("FAIL b2b addr c3: got %h expected 00100", addr0); end
      end
      if (c == 9) begin
        n_chk++; if (addr0 !== 20'h00200) begin n_fail++; $display("FAIL b2b addr c9: got %h expected 00200", addr0); end
      end
      step();
    end
    exp_rdata = 16'hC3C3;
    while (sb0.size() > 0) begin
      e = sb0.pop_front(); n_chk++;
      if (obs0.size() == 0) begin n_fail++; $display("FAIL b2b rsp: got none expected cycle %0d", e.cyc - c0); end
      else begin
        o = obs0.pop_front();
        if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin n_fail++; $display("FAIL b2b rsp: got c%0d %h expected c%0d %h", o.cyc - c0, o.rdata, e.cyc - c0, e.rdata); end
      end
    end
    n_chk++; if (obs0.size() != 0) begin n_fail++; $display("FAIL b2b extra rsp: got %0d expected 0", obs0.size()); end
    obs0.delete();
  endtask

  task automatic test_reset_abort();
    logic [6:0] ev;
    req0(1'b1, 20'h00003, 16'h1111, 2'b11, -1, 16'h0000);
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) bus0.req_valid = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      @(negedge clk);
      ev = (c >= 1 && c <= 3) ? {1'b0, (c >= 2) ? 1'b0 : 1'b1, 1'b1, 2'b00, 1'b1, 1'b0} : IDLE_V;
      n_chk++; if (pins0() !== ev) begin n_fail++; $display("FAIL abort pins c%0d: got %b expected %b", c, pins0(), ev); end
      step();
    end
    exp_rdata = 16'h0000;
    n_chk++; if (bus0.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL abort rsp_rdata: got %h expected 0000", bus0.rsp_rdata); end
    n_chk++; if (obs0.size() != 0) begin n_fail++; $display("FAIL abort rsp: got %0d responses expected 0", obs0.size()); end
    obs0.delete();
    obs1.delete();
  endtask

  task automatic test_params();
    logic        wr_t  [2] = '{1'b1, 1'b0};
    logic [1:0]  be_t  [2] = '{2'b10, 2'b11};
    logic [15:0] rd_t  [2] = '{16'h0000, 16'h5A5A};
    int          len_t [2] = '{7, 9};
    int c0;
    logic [6:0] ev;
    logic we_x, oe_x;
    rsp_t e, o;
    for (int k = 0; k < 2; k++) begin
      c0 = cyc;
      bus1.req_valid = 1'b1; bus1.req_write = wr_t[k]; bus1.req_addr = 20'h00007;
      bus1.req_wdata = 16'h0F0F; bus1.req_byte_en = be_t[k];
      e.cyc = c0 + len_t[k]; e.rdata = rd_t[k]; sb1.push_back(e);
      for (int c = 0; c <= len_t[k] + 1; c++) begin
        if (c == 1) bus1.req_valid = 1'b0;
        @(negedge clk);
        we_x = !(wr_t[k] && c == 3);
        oe_x = !(!wr_t[k] && c >= 3 && c <= 5);
        ev = (c >= 1 && c < len_t[k]) ? {1'b0, we_x, oe_x, ~be_t[k][0], ~be_t[k][1], wr_t[k], 1'b0} : IDLE_V;
        n_chk++; if (pins1() !== ev) begin n_fail++; $display("FAIL params op%0d pins c%0d: got %b expected %b", k, c, pins1(), ev); end
        n_chk++; if ((!we_n1 && !oe_n1) || (dq_oe1 && !oe_n1)) begin n_fail++; $display("FAIL params op%0d overlap c%0d: got we_n=%b oe_n=%b dq_oe=%b", k, c, we_n1, oe_n1, dq_oe1); end
        step();
      end
      while (sb1.size() > 0) begin
        e = sb1.pop_front(); n_chk++;
        if (obs1.size() == 0) begin n_fail++; $display("FAIL params op%0d rsp: got none expected cycle %0d", k, e.cyc - c0); end
        else begin
          o = obs1.pop_front();
          if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin n_fail++; $display("FAIL params op%0d rsp: got c%0d %h expected c%0d %h", k, o.cyc - c0, o.rdata, e.cyc - c0, e.rdata); end
        end
      end
      n_chk++; if (obs1.size() != 0) begin n_fail++; $display("FAIL params extra rsp: got %0d expected 0", obs1.size()); end
      obs1.delete();
    end
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0;   bus0.req_byte_en = 2'b00;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_byte_en = 2'b00;
    #1;
    test_reset();
    test_write();
    test_read();
    test_byte_read();
    test_back_to_back();
    test_reset_abort();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mram_bus_ctrl.md
# mram_bus_ctrl

Timing sequencer that sits directly downstream of the serial-to-parallel front end and owns the physical MRAM pins. It accepts one parallel transaction at a time (20-bit address, 16-bit write data, direction, byte enables) over a valid/ready handshake. It then runs a parameterised, counter-timed MRAM write or read cycle on the active-low control strobes. For reads, it captures the returned word and reports completion with a one-cycle response pulse.

## Interface
Parameters:
- SETUP_CYC, default 1: cycles with address, CE and byte enables asserted before the WE or OE strobe; minimum 1.
- WR_PULSE_CYC, default 3: cycles mram_we_n is held low; minimum 1.
- RD_ACCESS_CYC, default 3: cycles mram_oe_n is held low before data capture; minimum 1.
- HOLD_CYC, default 1: cycles after the strobe deasserts with address, data and CE held; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- req_valid  in  1  transaction request
- req_ready  out  1  block idle; request accepted when req_valid && req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  20  word address
- req_wdata  in  16  write data
- req_byte_en  in  2  active-high; bit0 = [7:0], bit1 = [15:8]
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  16  captured read data; disabled bytes read as 0
- mram_addr  out  20  MRAM address
- mram_dq_out  out  16  MRAM write data
- mram_dq_oe  out  1  DQ output enable (top level builds the IOBUF)
- mram_dq_in  in  16  MRAM read data
- mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n  out  1 each  active-low strobes

## Operation
- FSM states: IDLE, SETUP, WR_PULSE, RD_ACCESS, HOLD.
  - IDLE → SETUP on accept.
  - SETUP → WR_PULSE (write) or RD_ACCESS (read) after SETUP_CYC cycles.
  - WR_PULSE or RD_ACCESS → HOLD when its count expires.
  - HOLD → IDLE after HOLD_CYC cycles.
- On accept, the block latches addr, wdata, write and byte_en. All request inputs are ignored outside IDLE.
- req_ready = (state == IDLE).
- SETUP: ce_n=0; lb_n/ub_n = ~byte_en; we_n=1, oe_n=1. For writes, dq_oe=1 and dq_out = wdata.
- WR_PULSE: we_n=0; everything else as in SETUP.
- RD_ACCESS: oe_n=0, dq_oe=0. On the edge ending the last RD_ACCESS cycle, rsp_rdata ← mram_dq_in, with disabled bytes forced to 0.
- HOLD: we_n=1, oe_n=1; ce_n, addr, byte enables and (for writes) dq_oe/dq_out are held.
- On entering IDLE, rsp_valid pulses for exactly one cycle. rsp_rdata is updated only by reads and holds its value otherwise.
- All MRAM outputs are registered, with no combinational path from request inputs to pins.
- In IDLE: ce_n=we_n=oe_n=lb_n=ub_n=1, dq_oe=0; mram_addr and dq_out hold their last values.
- req_byte_en = 2'b00: the request is accepted and runs the full timing with lb_n = ub_n = 1; a read returns 0.
- Reset in the middle of a transaction aborts it. All outputs return to reset values on the next edge, and no rsp_valid is produced.

## Timing
- Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0; mram_addr=0; mram_dq_out=0; mram_dq_oe=0; all _n strobes=1.
- Cycle numbering: cycle 0 is the accept cycle.
  - Cycles 1..SETUP_CYC: SETUP.
  - Next P cycles: strobe, where P = WR_PULSE_CYC or RD_ACCESS_CYC.
  - Next HOLD_CYC cycles: HOLD.
  - Cycle 1+SETUP_CYC+P+HOLD_CYC: IDLE with rsp_valid=1.
- With defaults, rsp_valid asserts in cycle 6.
- Back-to-back: a request can be accepted in the rsp_valid cycle. This guarantees at least one IDLE cycle with ce_n=1 between transactions.
- WE and OE are never low simultaneously. dq_oe is never 1 while oe_n = 0.
- The cycle counter is $clog2(max param + 1) bits wide, loads param−1, and decrements to 0.

## Structure
- Shared package mram_pkg:
  - MRAM_ADDR_W=20, MRAM_DATA_W=16.
  - FSM state typedef.
  - Strobe idle-level constants, reused by the serial front end and the parallel-to-serial return stage.
- One sub-module, mram_cycle_timer: load/decrement counter with a done flag, instanced once.
- Simulation-only assertion that every parameter is ≥1.

## Test plan
- Write with defaults: addr=0x0A5C3, wdata=0xBEEF, be=2'b11 → we_n low in cycles 2–4; dq_oe=1 in cycles 1–5; ce_n low in cycles 1–5; rsp_valid in cycle 6.
- Read: addr=0x00010 with the model driving 0x1234 → oe_n low in cycles 2–4; dq_oe=0 throughout; rsp_rdata=0x1234 with rsp_valid in cycle 6.
- Byte read: be=2'b01, model drives 0xABCD → ub_n=1, lb_n=0; rsp_rdata=0x00CD.
- Back-to-back: write then read, with req_valid held high → second accept in cycle 6; ce_n=1 in cycle 6 only; second rsp_valid in cycle 12.
- rst asserted in cycle 3 of a write → we_n=1, dq_oe=0, req_ready=1 on the next edge; no rsp_valid.
- Parameters SETUP=2, WR=1, HOLD=3 → we_n low in cycle 3 only; rsp_valid in cycle 7; no strobe overlap throughout.
